// File: rtl/sy_fifo_nibble_packer.sv
// Drain stage for a 4-bit synchronous FIFO: packs PACK nibbles LSB-first into one word,
// presents it on valid/ready, supports flushing a partial word and flags errors stickily.
module sy_fifo_nibble_packer #(
  parameter int WIDTH = 4,
  parameter int PACK  = 4,
  parameter int CNT_W = $clog2(PACK) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_empty_i,
  input  logic [WIDTH-1:0]      fifo_rdata_i,
  input  logic                  fifo_error_i,
  output logic                  fifo_rd_en_o,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH*PACK-1:0] out_data_o,
  output logic [CNT_W-1:0]      out_count_o,
  output logic                  err_o
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_q;
  logic                  flush_pend_q, flush_pend_d;
  logic                  valid_q, valid_d;
  logic [WIDTH*PACK-1:0] data_q, data_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  err_q, err_d;
  logic [CNT_W:0]        inflight;

  // Nibbles already captured plus the one still in flight must not exceed a word.
  assign inflight = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_q};

  assign fifo_rd_en_o = (state_q == FILL) && !fifo_empty_i && !flush_pend_q &&
                        (inflight < (CNT_W+1)'(PACK)) && !rst_i;

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_count_o = count_q;
  assign err_o       = err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    data_d       = data_q;
    count_d      = count_q;
    flush_pend_d = flush_pend_q | flush_i;
    err_d        = err_q | fifo_error_i | (pend_q && (state_q == HOLD));
    case (state_q)
      FILL: begin
        if (pend_q) begin
          for (int k = 0; k < PACK; k++) begin
            if (cnt_q == CNT_W'(k)) data_d[k*WIDTH +: WIDTH] = fifo_rdata_i;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(PACK)) begin
            state_d = HOLD;
            valid_d = 1'b1;
            count_d = CNT_W'(PACK);
          end
        end else if (flush_pend_q) begin
          // A flush only completes once no read is outstanding; empty flushes emit nothing.
          flush_pend_d = flush_i;
          if (cnt_q != '0) begin
            state_d = HOLD;
            valid_d = 1'b1;
            count_d = cnt_q;
          end
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          state_d = FILL;
          valid_d = 1'b0;
          cnt_d   = '0;
          data_d  = '0;
          count_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= fifo_rd_en_o;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_sy_fifo_nibble_packer.sv
// Self-checking bench for sy_fifo_nibble_packer: FIFO model with 1-cycle read latency,
// table vectors, hand-written corner sequences and a randomized packing scoreboard.
module tb_sy_fifo_nibble_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic [3:0]  rdata = 4'h0;
  logic        fifo_error = 1'b0;
  logic        rd_en;
  logic        flush = 1'b0;
  logic        valid;
  logic        ready = 1'b0;
  logic [15:0] data;
  logic [2:0]  count;
  logic        err;

  sy_fifo_nibble_packer dut (
    .clk_i(clk), .rst_i(rst), .fifo_empty_i(fifo_empty), .fifo_rdata_i(rdata),
    .fifo_error_i(fifo_error), .fifo_rd_en_o(rd_en), .flush_i(flush),
    .out_valid_o(valid), .out_ready_i(ready), .out_data_o(data),
    .out_count_o(count), .err_o(err)
  );

  always #5 clk = ~clk;

  // FIFO model: unbounded buffer, data appears the cycle after an accepted read.
  logic [3:0] push_buf [0:1023];
  int         push_total = 0;
  int         pop_idx = 0;
  logic       rd_seen = 1'b0;

  assign fifo_empty = (pop_idx == push_total);

  always @(negedge clk) rd_seen = rd_en;

  always @(posedge clk) begin
    #2;
    if (rst) pop_idx = push_total;
    else if (rd_seen && pop_idx < push_total) begin
      rdata = push_buf[pop_idx];
      pop_idx++;
    end
  end

  int          checks = 0;
  int          failures = 0;
  int          rd_total = 0;
  int          word_total = 0;
  logic [15:0] got_data [0:255];
  logic [2:0]  got_cnt  [0:255];
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [15:0] prev_data = 16'h0;
  logic [2:0]  prev_count = 3'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] n);
    push_buf[push_total] = n;
    push_total++;
  endtask

  // One clock cycle: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (!rst) begin
      chk("rd_while_empty", rd_en && fifo_empty, 0);
      chk("rd_while_valid", rd_en && valid, 0);
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", valid, 1);
        chk("hold_data", data, prev_data);
        chk("hold_count", count, prev_count);
      end
      if (rd_en) rd_total++;
      if (valid && ready) begin
        got_data[word_total] = data;
        got_cnt[word_total]  = count;
        word_total++;
      end
      prev_valid = valid;
      prev_ready = ready;
      prev_data  = data;
      prev_count = count;
    end else begin
      chk("rd_in_reset", rd_en, 0);
      prev_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  typedef struct {
    logic [3:0]  n0, n1, n2, n3;
    int          num;
    logic        do_flush;
    int          delay;
    logic [15:0] exp_word;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int w0, r0, b0, pushed;
    logic [15:0] w;

    vecs[0] = '{4'h1, 4'h2, 4'h3, 4'h4, 4, 1'b0, 0, 16'h4321, 3'd4};
    vecs[1] = '{4'h8, 4'h9, 4'hA, 4'hB, 4, 1'b0, 5, 16'hBA98, 3'd4};
    vecs[2] = '{4'hC, 4'hD, 4'hE, 4'hF, 4, 1'b0, 2, 16'hFEDC, 3'd4};
    vecs[3] = '{4'h5, 4'h6, 4'h7, 4'h0, 3, 1'b1, 0, 16'h0765, 3'd3};
    vecs[4] = '{4'h9, 4'h0, 4'h0, 4'h0, 1, 1'b1, 3, 16'h0009, 3'd1};
    vecs[5] = '{4'h0, 4'hF, 4'h0, 4'hF, 4, 1'b0, 1, 16'hF0F0, 3'd4};
    vecs[6] = '{4'h3, 4'hC, 4'h0, 4'h0, 2, 1'b1, 0, 16'h00C3, 3'd2};

    // Reset state
    run(3);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    run(2);

    // Plan 1: four nibbles, ready high
    ready = 1'b1;
    r0 = rd_total; w0 = word_total;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    run(12);
    chk("p1_reads", rd_total - r0, 4);
    chk("p1_words", word_total - w0, 1);
    chk("p1_data", got_data[w0], 16'h4321);
    chk("p1_count", got_cnt[w0], 4);
    chk("p1_valid_after", valid, 0);

    // Plan 2: eight nibbles with ready held low
    ready = 1'b0;
    r0 = rd_total; w0 = word_total;
    for (int i = 8; i < 16; i++) push(4'(i));
    run(12);
    chk("p2_valid", valid, 1);
    chk("p2_hold_data", data, 16'hBA98);
    chk("p2_reads_in_hold", rd_total - r0, 4);
    ready = 1'b1;
    run(15);
    chk("p2_words", word_total - w0, 2);
    chk("p2_first", got_data[w0], 16'hBA98);
    chk("p2_second", got_data[w0+1], 16'hFEDC);

    // Table vectors, including flushed partial words
    for (int v = 0; v < 7; v++) begin
      ready = 1'b0;
      w0 = word_total;
      if (vecs[v].num > 0) push(vecs[v].n0);
      if (vecs[v].num > 1) push(vecs[v].n1);
      if (vecs[v].num > 2) push(vecs[v].n2);
      if (vecs[v].num > 3) push(vecs[v].n3);
      run(8);
      if (vecs[v].do_flush) begin
        chk("tv_no_early_word", valid, 0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        run(3);
      end
      chk("tv_valid", valid, 1);
      chk("tv_data", data, vecs[v].exp_word);
      chk("tv_count", count, vecs[v].exp_count);
      run(vecs[v].delay);
      ready = 1'b1;
      run(2);
      ready = 1'b0;
      chk("tv_words", word_total - w0, 1);
      chk("tv_got_data", got_data[w0], vecs[v].exp_word);
      chk("tv_got_count", got_cnt[w0], vecs[v].exp_count);
      chk("tv_valid_after", valid, 0);
    end

    // Plan 4: flush with nothing captured
    ready = 1'b1;
    r0 = rd_total; w0 = word_total;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    run(6);
    chk("p4_words", word_total - w0, 0);
    chk("p4_reads", rd_total - r0, 0);
    chk("p4_valid", valid, 0);

    // Plan 5: FIFO runs dry mid-word
    r0 = rd_total; w0 = word_total;
    push(4'h1); push(4'h2);
    run(20);
    chk("p5_reads_partial", rd_total - r0, 2);
    chk("p5_no_word", word_total - w0, 0);
    push(4'h3); push(4'h4);
    run(10);
    chk("p5_words", word_total - w0, 1);
    chk("p5_data", got_data[w0], 16'h4321);
    chk("p5_count", got_cnt[w0], 4);

    // Randomized packing against a scoreboard of pushed nibbles
    w0 = word_total; b0 = push_total; pushed = 0;
    for (int c = 0; c < 400 && pushed < 48; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        push(4'($urandom_range(0, 15)));
        pushed++;
      end
      ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    ready = 1'b1;
    run(40);
    chk("rnd_words", word_total - w0, 12);
    for (int i = 0; i < 12; i++) begin
      w = 16'h0;
      for (int j = 0; j < 4; j++) w = w | (16'(push_buf[b0 + 4*i + j]) << (4*j));
      chk("rnd_data", got_data[w0 + i], w);
      chk("rnd_count", got_cnt[w0 + i], 4);
    end
    chk("rnd_err_clear", err, 0);

    // Plan 6a: sticky error
    fifo_error = 1'b1;
    cyc();
    fifo_error = 1'b0;
    cyc();
    chk("err_set", err, 1);
    run(5);
    chk("err_sticky", err, 1);
    rst = 1'b1;
    run(2);
    chk("err_cleared", err, 0);
    rst = 1'b0;
    run(2);

    // Plan 6b: reset after two of four nibbles
    ready = 1'b1;
    w0 = word_total;
    push(4'h1); push(4'h2);
    run(3);
    rst = 1'b1;
    cyc();
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_count", count, 0);
    rst = 1'b0;
    run(2);
    chk("mid_rst_no_word", word_total - w0, 0);
    push(4'hA); push(4'hB); push(4'hC); push(4'hD);
    run(12);
    chk("post_rst_words", word_total - w0, 1);
    chk("post_rst_data", got_data[w0], 16'hDCBA);
    chk("post_rst_count", got_cnt[w0], 4);
    chk("post_rst_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sy_fifo_nibble_packer.md
Name: sy_fifo_nibble_packer

Overview:
Downstream drain stage for the 16-deep, 4-bit synchronous FIFO. It pops nibbles from the FIFO read port and packs PACK consecutive nibbles, LSB-first, into one output word. The word is presented on a valid/ready handshake. A flush request emits a partial word, and the block reports FIFO error and protocol violations on a sticky flag.

Parameters:
WIDTH, 4, FIFO data width in bits (nibble)
PACK, 4, nibbles per output word; output width is WIDTH*PACK
CNT_W, $clog2(PACK)+1, width of the nibble counter and out_count_o

Ports:
clk_i  in  1  clock; all logic on posedge
rst_i  in  1  synchronous, active-high reset (shared with FIFO)
fifo_empty_i  in  1  FIFO empty flag
fifo_rdata_i  in  WIDTH  FIFO read data, valid the cycle after an accepted rd_en
fifo_error_i  in  1  FIFO error flag (over/underflow)
fifo_rd_en_o  out  1  FIFO read enable
flush_i  in  1  single-cycle request to emit the current partial word
out_valid_o  out  1  output word valid
out_ready_i  in  1  consumer ready
out_data_o  out  WIDTH*PACK  packed word; lane k = nibble k, LSB-first
out_count_o  out  CNT_W  number of valid nibbles in out_data_o (1..PACK)
err_o  out  1  sticky error

Behaviour:
- Reset (rst_i=1 at a clock edge) drives state=FILL, cnt=0, pend=0, flush_pend=0, out_valid_o=0, out_data_o=0, out_count_o=0, err_o=0.
- fifo_rd_en_o is forced to 0 while rst_i=1.
- FIFO read latency is 1: fifo_rd_en_o=1 in cycle N delivers data in cycle N+1. The pend register records that a read was issued last cycle.
- fifo_rd_en_o is combinational: (state==FILL) && !fifo_empty_i && !flush_pend && (cnt+pend < PACK) && !rst_i.
- fifo_rd_en_o is never asserted while fifo_empty_i=1.
- Capture: when pend=1, fifo_rdata_i is written into lane cnt and cnt increments. Lanes at or above cnt are held at 0.
- Back-to-back reads are allowed, giving one nibble per cycle in FILL.
- State FILL -> HOLD when a capture makes cnt==PACK.
  - In that cycle: out_valid_o<=1, out_count_o<=PACK, and out_data_o takes the completed word.
- Flush, part 1: flush_i=1 in any state sets flush_pend. While flush_pend=1, no new reads are issued.
- Flush, part 2: in FILL with flush_pend=1 and pend=0:
  - if cnt>0, go to HOLD with out_count_o=cnt, unused lanes 0, and clear flush_pend;
  - if cnt==0, clear flush_pend and emit nothing.
- State HOLD:
  - out_valid_o=1; out_data_o and out_count_o stay stable until out_ready_i=1.
  - No FIFO reads are issued.
- HOLD -> FILL on out_valid_o && out_ready_i. Next cycle: out_valid_o=0, cnt=0, out_data_o cleared.
  - A flush_pend still set at that point is cleared in the first FILL cycle, since cnt=0 and pend=0.
- Throughput with ready held at 1: PACK nibbles per PACK+2 cycles (one HOLD cycle plus one restart cycle).
- err_o is set and held until reset when either:
  - fifo_error_i=1 in any cycle; or
  - pend=1 coincides with state==HOLD, which is a protocol violation and must never occur in correct RTL.
- Reset mid-word or mid-HOLD: partial data and any pending read are discarded, and no output is produced. The FIFO is reset by the same rst_i.
- Simultaneous flush_i and a capture that completes the word: the full word is emitted with count PACK, and flush_pend clears on return to FILL.

Test Plan:
1. Push 0x1,0x2,0x3,0x4 with out_ready_i=1 -> exactly 4 fifo_rd_en_o pulses; one word out_data_o=0x4321, out_count_o=4; then out_valid_o=0.
2. Push 8 nibbles 0x8..0xF with out_ready_i=0 for 12 cycles -> first word 0xBA98 held stable, fifo_rd_en_o=0 throughout HOLD; after ready, second word 0xFEDC.
3. Push 0x5,0x6,0x7, wait idle, pulse flush_i -> one word 0x0765 with out_count_o=3; cnt returns to 0.
4. Pulse flush_i with FIFO empty and cnt=0 -> out_valid_o stays 0, no reads issued.
5. Push 0x1,0x2, keep the FIFO empty 20 cycles, push 0x3,0x4 -> no fifo_rd_en_o while empty; single word 0x4321.
6. Force fifo_error_i=1 for one cycle -> err_o=1 until rst_i. Separately, assert rst_i after 2 of 4 nibbles -> all outputs 0, no word emitted, next 4 nibbles pack correctly.
